gru_gate_row_sequencer: RTL and testbench

Time-multiplexes one GRU gate element (Q16.8 datapath, sigmoid output) over all `H` hidden rows. It issues row addresses to the synchronous weight/bias memory and drives the element's `valid_in` aligned with the returned row data. It also collects the element's registered `z_t_n`/`valid_out` results into an `H`-entry output vector. It sits between the layer controller (start/done) and one gate element plus its weight memory.

---
 rtl/gru_pkg.sv | 19 +
 rtl/gru_valid_delay.sv | 32 +++
 rtl/gru_gate_row_sequencer.sv | 165 ++++++++++++++++
 tb/tb_gru_gate_row_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gru_pkg.sv
// Shared types and constants for the GRU gate datapath (Q16.8 words).
package gru_pkg;

  localparam int INT_BITS   = 16;
  localparam int FRAC_BITS  = 8;
  localparam int DATA_WIDTH = INT_BITS + FRAC_BITS;

  typedef logic signed [DATA_WIDTH-1:0] fixed_t;

  localparam fixed_t ONE_FIXED = 24'sd256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/gru_valid_delay.sv
// 1-bit valid delay line of DEPTH stages with async reset and synchronous flush.
module gru_valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  always_comb begin
    sr_d    = sr_q << 1;
    sr_d[0] = d_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (flush_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/gru_gate_row_sequencer.sv
// Time-multiplexes one GRU gate element across H hidden rows and gathers its results.
// Protocol/range checking on err_o is built only when GRU_SEQ_ERR_CHECK_EN is defined.
module gru_gate_row_sequencer
  import gru_pkg::*;
#(
  parameter int H            = 256,
  parameter int INT_BITS     = 16,
  parameter int FRAC_BITS    = 8,
  parameter int DATA_WIDTH   = INT_BITS + FRAC_BITS,
  parameter int MEM_LATENCY  = 1,
  parameter int GATE_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic                         abort_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         mem_rd_en_o,
  output logic [$clog2(H)-1:0]         mem_addr_o,
  output logic                         gate_valid_in_o,
  input  logic signed [DATA_WIDTH-1:0] gate_z_i,
  input  logic                         gate_valid_out_i,
  output logic signed [DATA_WIDTH-1:0] z_vec_o [H],
  output logic                         err_o
);

  localparam int AW = $clog2(H);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ROWS     = CW'(H);
  localparam logic [CW-1:0] LAST_ROW = CW'(H - 1);

  if (MEM_LATENCY < 1 || GATE_LATENCY < 1 || FRAC_BITS >= DATA_WIDTH) begin : g_cfg_check
    $error("gru_gate_row_sequencer: unsupported latency or fixed-point configuration");
  end

  seq_state_t                   state_q;
  logic [CW-1:0]                issue_cnt_q;
  logic [CW-1:0]                collect_cnt_q;
  logic                         busy_q;
  logic                         done_q;
  logic                         rd_en_q;
  logic [AW-1:0]                addr_q;
  logic signed [DATA_WIDTH-1:0] z_q [H];
  logic                         active;
  logic                         collect_en;
  logic                         flush;

  assign active     = (state_q == ISSUE) || (state_q == DRAIN);
  assign collect_en = gate_valid_out_i && active;
  assign flush      = abort_i && active;

  // issue_cnt_q holds the next row to read; reads stay registered so mem_addr is glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      issue_cnt_q   <= '0;
      collect_cnt_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_en_q       <= 1'b0;
      addr_q        <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q       <= ISSUE;
            busy_q        <= 1'b1;
            rd_en_q       <= 1'b1;
            addr_q        <= '0;
            issue_cnt_q   <= CW'(1);
            collect_cnt_q <= '0;
          end
        end
        ISSUE, DRAIN: begin
          if (abort_i) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            rd_en_q       <= 1'b0;
            issue_cnt_q   <= '0;
            collect_cnt_q <= '0;
          end else begin
            if (state_q == ISSUE) begin
              if (issue_cnt_q == ROWS) begin
                rd_en_q <= 1'b0;
                state_q <= DRAIN;
              end else begin
                addr_q      <= issue_cnt_q[AW-1:0];
                issue_cnt_q <= issue_cnt_q + 1'b1;
              end
            end
            if (collect_en) begin
              collect_cnt_q <= collect_cnt_q + 1'b1;
              if (collect_cnt_q == LAST_ROW) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // result vector: each collect lands at the running collect index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < H; i++) begin
        z_q[i] <= '0;
      end
    end else if (collect_en && (collect_cnt_q < ROWS)) begin
      z_q[collect_cnt_q[AW-1:0]] <= gate_z_i;
    end
  end

  gru_valid_delay #(
    .DEPTH(MEM_LATENCY)
  ) u_valid_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(flush),
    .d_i    (rd_en_q),
    .q_o    (gate_valid_in_o)
  );

`ifdef GRU_SEQ_ERR_CHECK_EN
  localparam logic signed [DATA_WIDTH-1:0] ONE_Q = DATA_WIDTH'(1) << FRAC_BITS;

  logic err_q;
  logic err_hit;

  assign err_hit = (gate_valid_out_i && ((state_q == IDLE) || (state_q == DONE)))
                || (collect_en && ((collect_cnt_q >= ROWS)
                                   || gate_z_i[DATA_WIDTH-1]
                                   || (gate_z_i > ONE_Q)));

  // sticky until reset; out-of-range results are still stored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | err_hit;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign mem_rd_en_o = rd_en_q;
  assign mem_addr_o  = addr_q;
  assign z_vec_o     = z_q;

endmodule

// File: tb/tb_gru_gate_row_sequencer.sv
// Randomized directed bench for gru_gate_row_sequencer with a cycle-timing and result-vector model.
module tb_gru_gate_row_sequencer;

  localparam int H  = 8;
  localparam int L  = 2;
  localparam int G  = 1;
  localparam int DW = 24;
  localparam int AW = $clog2(H);
`ifdef GRU_SEQ_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start_i = 1'b0;
  logic                 abort_i = 1'b0;
  logic                 gate_valid_out_i = 1'b0;
  logic signed [DW-1:0] gate_z_i = '0;
  logic                 busy_o, done_o, mem_rd_en_o, gate_valid_in_o, err_o;
  logic [AW-1:0]        mem_addr_o;
  logic signed [DW-1:0] z_vec_o [H];

  gru_gate_row_sequencer #(
    .H(H), .INT_BITS(16), .FRAC_BITS(8), .DATA_WIDTH(DW),
    .MEM_LATENCY(L), .GATE_LATENCY(G)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o),
    .gate_valid_in_o(gate_valid_in_o), .gate_z_i(gate_z_i), .gate_valid_out_i(gate_valid_out_i),
    .z_vec_o(z_vec_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic hist_gvi [4096];
  int   hist_addr [4096];
  int   row_data [H];
  int   exp_z [H];
  logic exp_err = 1'b0;
  logic inject = 1'b0;
  int   inject_z = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic chk_zvec();
    for (int i = 0; i < H; i++) begin
      chk($sformatf("z_vec%0d", i), z_vec_o[i], exp_z[i]);
    end
  endtask

  // Advance one cycle, then play the gate element: it answers G cycles after valid_in
  // with the data of the row that was read L cycles before that.
  task automatic tick();
    int src;
    @(posedge clk);
    #1;
    cyc++;
    hist_gvi[cyc]  = gate_valid_in_o;
    hist_addr[cyc] = int'(mem_addr_o);
    src = cyc - G;
    if (inject) begin
      gate_valid_out_i = 1'b1;
      gate_z_i         = DW'(inject_z);
    end else if ((src - L >= 0) && hist_gvi[src]) begin
      gate_valid_out_i = 1'b1;
      gate_z_i         = DW'(row_data[hist_addr[src-L]]);
    end else begin
      gate_valid_out_i = 1'b0;
      gate_z_i         = DW'($urandom);
    end
  endtask

  // One pass started now; abort_r>0 aborts in that relative cycle, poke_r>0 pulses start there.
  task automatic run_pass(input int abort_r, input int poke_r, input int bad_row);
    int last, r_end, row;
    bit e_busy, e_rd, e_gvi, e_done, e_vout;
    for (int n = 0; n < H; n++) row_data[n] = int'($urandom_range(0, 256));
    if (bad_row >= 0) row_data[bad_row] = 257;
    last  = (abort_r > 0) ? abort_r : (1 << 20);
    r_end = (abort_r > 0) ? (abort_r + G + 2) : (H + L + G + 1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int r = 1; r <= r_end; r++) begin
      e_busy = (r <= H + L + G) && (r <= last);
      e_rd   = (r <= H) && (r <= last);
      e_gvi  = (r >= 1 + L) && (r <= H + L) && (r <= last);
      e_done = (abort_r == 0) && (r == H + L + G + 1);
      chk("busy", busy_o, e_busy);
      chk("done", done_o, e_done);
      chk("mem_rd_en", mem_rd_en_o, e_rd);
      chk("gate_valid_in", gate_valid_in_o, e_gvi);
      chk("err", err_o, exp_err);
      if (e_rd) chk("mem_addr", mem_addr_o, r - 1);
      e_vout = (r - G >= 1 + L) && (r - G <= H + L) && (r - G <= last);
      row    = r - G - L - 1;
      if (e_vout && (r > last)) exp_err = exp_err | ERR_EN;
      if (e_vout && (r <= last) && (row_data[row] > 256)) exp_err = exp_err | ERR_EN;
      abort_i = (r == abort_r);
      start_i = (r == poke_r);
      tick();
    end
    abort_i = 1'b0;
    start_i = 1'b0;
    for (int n = 0; n < H; n++) begin
      if (1 + L + G + n <= last) exp_z[n] = row_data[n];
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_err = 1'b0;
    for (int n = 0; n < H; n++) exp_z[n] = 0;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_rd_en", mem_rd_en_o, 1'b0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_gvi", gate_valid_in_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk_zvec();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      hist_gvi[i]  = 1'b0;
      hist_addr[i] = 0;
    end
    for (int n = 0; n < H; n++) begin
      row_data[n] = 0;
      exp_z[n]    = 0;
    end
    tick();
    do_reset();
    tick();

    // start re-pulsed in relative cycle 3 is ignored
    run_pass(0, 3, -1);
    chk_zvec();
    // start in the DONE cycle is ignored, the very next cycle it is accepted
    run_pass(0, H + L + G + 1, -1);
    chk("start_in_done_ignored", busy_o, 1'b0);
    run_pass(0, 0, -1);
    chk_zvec();

    // abort: partial writes stay, late element results are dropped
    run_pass(L + G + 2, 0, -1);
    chk_zvec();
    run_pass(0, 0, -1);
    chk_zvec();

    for (int k = 0; k < 4; k++) begin
      repeat (int'($urandom_range(0, 3))) tick();
      if ($urandom_range(0, 1) == 1) run_pass(int'($urandom_range(2, H + L + G - 1)), 0, -1);
      else run_pass(0, 0, -1);
      chk_zvec();
    end

    // spurious element result while idle
    inject   = 1'b1;
    inject_z = 5;
    tick();
    inject  = 1'b0;
    exp_err = exp_err | ERR_EN;
    tick();
    chk("err_spurious", err_o, exp_err);
    tick();
    chk("err_sticky", err_o, exp_err);
    chk_zvec();

    // out-of-range result 0x101 is flagged and still stored
    do_reset();
    run_pass(0, 0, 3);
    chk("err_range", err_o, exp_err);
    chk_zvec();

    // asynchronous reset in the middle of a pass
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    do_reset();
    run_pass(0, 0, -1);
    chk_zvec();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
